// File: rtl/alu_pkg.sv
// Shared ALU op codes, FSM state encoding and a legality helper used by the
// multicycle execution unit and its upstream decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } alu_state_e;

    // Unknown bits never match a legal code, so X decodes as illegal.
    function automatic logic is_legal_op(input logic [3:0] code);
        logic legal;
        legal = 1'b0;
        case (code)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SRL: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/srl_step.sv
// One iteration of the iterative logical right shift: shifts by at most Step bits
// and reports how much of the requested amount remains.
module srl_step #(
    parameter int unsigned  Width = 32,
    parameter int unsigned  Step  = 1,
    localparam int unsigned AmtW  = $clog2(Width)
) (
    input  logic [Width-1:0] value_i,
    input  logic [AmtW-1:0]  amount_i,
    output logic [Width-1:0] value_o,
    output logic [AmtW-1:0]  amount_o
);

    // One extra bit so Step == Width is representable.
    localparam logic [AmtW:0] StepW = (AmtW + 1)'(Step);

    logic [AmtW:0] take;

    always_comb begin
        take     = ({1'b0, amount_i} < StepW) ? {1'b0, amount_i} : StepW;
        value_o  = value_i >> take;
        amount_o = amount_i - take[AmtW-1:0];
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready on both sides: single-cycle ADD/SUB/AND/OR and an
// iterative SRL that shifts SHIFT_STEP bits per cycle.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned AmtW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] shift_val_q, shift_val_d;
    logic [AmtW-1:0]  shift_amt_q, shift_amt_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic [AmtW-1:0]  req_amt;
    logic [WIDTH-1:0] step_val;
    logic [AmtW-1:0]  step_amt;

    assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    assign accept   = in_valid & in_ready;
    assign req_amt  = op_b[AmtW-1:0];

    srl_step #(
        .Width (WIDTH),
        .Step  (SHIFT_STEP)
    ) u_srl_step (
        .value_i  (shift_val_q),
        .amount_i (shift_amt_q),
        .value_o  (step_val),
        .amount_o (step_amt)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        shift_val_d = shift_val_q;
        shift_amt_d = shift_amt_q;
        illegal_d   = illegal_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d   = StDone;
                    illegal_d = ~is_legal_op(alu_control);
                    case (alu_control)
                        ALU_ADD: result_d = op_a + op_b;
                        ALU_SUB: result_d = op_a + ~op_b + WIDTH'(1);
                        ALU_AND: result_d = op_a & op_b;
                        ALU_OR:  result_d = op_a | op_b;
                        ALU_SRL: begin
                            if (req_amt == '0) begin
                                result_d = op_a;
                            end else begin
                                shift_val_d = op_a;
                                shift_amt_d = req_amt;
                                state_d     = StShift;
                            end
                        end
                        default: result_d = '0;
                    endcase
                end else if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                shift_val_d = step_val;
                shift_amt_d = step_amt;
                if (step_amt == '0) begin
                    result_d = step_val;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            result_q    <= '0;
            shift_val_q <= '0;
            shift_amt_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            shift_val_q <= shift_val_d;
            shift_amt_q <= shift_amt_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized self-checking bench for alu_multicycle; two instances (SHIFT_STEP 1 and 4)
// share the stimulus and are checked against an arithmetic reference model.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  alu_control;
    logic [31:0] op_a, op_b;
    logic        out_ready;

    logic        in_ready1, out_valid1, zero1, illegal1;
    logic [31:0] result1;
    logic        in_ready4, out_valid4, zero4, illegal4;
    logic [31:0] result4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32), .SHIFT_STEP(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready1),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid1),
        .out_ready   (out_ready),
        .result      (result1),
        .zero        (zero1),
        .illegal     (illegal1)
    );

    alu_multicycle #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready4),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid4),
        .out_ready   (out_ready),
        .result      (result4),
        .zero        (zero4),
        .illegal     (illegal4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic void model(input logic [3:0] code, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res,
                                  output logic ill);
        ill = 1'b0;
        case (code)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SRL: res = a >> (b % 32);
            default: begin res = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    function automatic int latency(input logic [3:0] code, input logic [31:0] b,
                                   input int step);
        int n;
        n = int'(b % 32);
        if (code == ALU_SRL && n > 0) return 1 + (n + step - 1) / step;
        return 1;
    endfunction

    // Issue one op with out_ready=1 and track each instance to its result.
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input bit chk_vals);
        logic [31:0] exp_res;
        logic        exp_ill;
        int          lat1, lat4;
        bit          done1, done4;
        model(code, a, b, exp_res, exp_ill);
        lat1 = latency(code, b, 1);
        lat4 = latency(code, b, 4);
        @(negedge clk);
        in_valid    = 1'b1;
        alu_control = code;
        op_a        = a;
        op_b        = b;
        out_ready   = 1'b1;
        #1;
        check("in_ready_at_issue", {31'd0, in_ready1 & in_ready4}, 32'd1);
        @(negedge clk);
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        op_a        = $urandom;
        op_b        = $urandom;
        done1 = 1'b0;
        done4 = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (!done1) begin
                if (out_valid1) begin
                    done1 = 1'b1;
                    check("latency_s1", cyc, lat1);
                    if (chk_vals) begin
                        check("result_s1", result1, exp_res);
                        check("zero_s1", {31'd0, zero1}, {31'd0, exp_res == 32'd0});
                        check("illegal_s1", {31'd0, illegal1}, {31'd0, exp_ill});
                    end
                end else begin
                    check("busy_in_ready_s1", {31'd0, in_ready1}, 32'd0);
                end
            end
            if (!done4) begin
                if (out_valid4) begin
                    done4 = 1'b1;
                    check("latency_s4", cyc, lat4);
                    if (chk_vals) begin
                        check("result_s4", result4, exp_res);
                        check("illegal_s4", {31'd0, illegal4}, {31'd0, exp_ill});
                    end
                end else begin
                    check("busy_in_ready_s4", {31'd0, in_ready4}, 32'd0);
                end
            end
            if (done1 && done4) break;
            @(negedge clk);
        end
        check("completed_s1", {31'd0, done1}, 32'd1);
        check("completed_s4", {31'd0, done4}, 32'd1);
        if (done1 && done4) begin
            @(negedge clk);
            check("back_to_idle", {30'd0, out_valid1, out_valid4}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  code;
        logic [31:0] a, b;
        int          r;

        reset = 1'b1; in_valid = 1'b0; alu_control = 4'd0;
        op_a = 32'd0; op_b = 32'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {30'd0, in_ready1, in_ready4}, 32'd3);
        check("rst_out_valid", {30'd0, out_valid1, out_valid4}, 32'd0);
        check("rst_result", result1 | result4, 32'd0);
        check("rst_zero", {30'd0, zero1, zero4}, 32'd3);
        check("rst_illegal", {30'd0, illegal1, illegal4}, 32'd0);
        reset = 1'b0;

        run_op(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        run_op(ALU_SUB, 32'd5, 32'd5, 1'b1);
        run_op(ALU_SRL, 32'h8000_0000, 32'd31, 1'b1);
        run_op(ALU_SRL, 32'hDEAD_BEEF, 32'd32, 1'b1);
        run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        run_op(4'bxxxx, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

        // Backpressure: AND result held while out_ready=0, in_valid ignored meanwhile.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; alu_control = ALU_AND;
        op_a = 32'hF0F0_F0F0; op_b = 32'hFF00_FF00;
        @(negedge clk);
        alu_control = ALU_ADD; op_a = 32'h1111_1111; op_b = 32'h2222_2222;
        check("bp_valid", {30'd0, out_valid1, out_valid4}, 32'd3);
        check("bp_result", result1, 32'hF000_F000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_s1", result1, 32'hF000_F000);
            check("bp_hold_s4", result4, 32'hF000_F000);
            check("bp_in_ready", {30'd0, in_ready1, in_ready4}, 32'd0);
            check("bp_valid_hold", {30'd0, out_valid1, out_valid4}, 32'd3);
        end
        out_ready = 1'b1; alu_control = ALU_OR; op_a = 32'h1234_0000; op_b = 32'h0000_5678;
        #1;
        check("bp_release_ready", {30'd0, in_ready1, in_ready4}, 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_valid", {30'd0, out_valid1, out_valid4}, 32'd3);
        check("b2b_result", result1, 32'h1234_5678);
        check("b2b_result_s4", result4, 32'h1234_5678);
        @(negedge clk);
        check("b2b_drain", {30'd0, out_valid1, out_valid4}, 32'd0);

        // Reset three cycles into a 20-bit SRL.
        @(negedge clk);
        in_valid = 1'b1; alu_control = ALU_SRL; op_a = 32'hFFFF_FFFF; op_b = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_out_valid", {30'd0, out_valid1, out_valid4}, 32'd0);
        check("midrst_result", result1 | result4, 32'd0);
        check("midrst_zero", {30'd0, zero1, zero4}, 32'd3);
        check("midrst_in_ready", {30'd0, in_ready1, in_ready4}, 32'd3);
        run_op(ALU_ADD, 32'd2, 32'd3, 1'b1);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 6);
            a = $urandom;
            b = $urandom;
            case (r)
                0: code = ALU_ADD;
                1: code = ALU_SUB;
                2: code = ALU_AND;
                3: code = ALU_OR;
                4: begin code = ALU_SRL; b = 32'($urandom_range(0, 12)); end
                5: code = ALU_SRL;
                default: code = 4'($urandom);
            endcase
            run_op(code, a, b, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
